adder_seq_ctrl: RTL

- Tiny Tapeout top-level that turns a shared 8-bit adder slice into an NBYTES-wide multi-byte adder.
- Operands A and B are streamed in one byte per cycle, LSB first, on ui_in.
- The sum is computed byte-serially, with the carry held in a register between bytes.
- Result bytes are then streamed out on uo_out under a read strobe; status flags are driven on the upper uio pins.

---
 rtl/adder_seq_pkg.sv | 35 +++
 rtl/adder8_cin.sv | 18 +
 rtl/adder_seq_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared types and constants for the byte-serial multi-byte adder
//
// Contents:
//   state_t    FSM state encoding (LOAD_A, LOAD_B, ADD, DONE)
//   UIO_*      bit positions on the uio_in / uio_out pins
//   UIO_OE     constant output-enable pattern: upper five uio pins are outputs
//   idx_width  byte-counter width for a given byte count (never below 1)
package adder_seq_pkg;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      ADD    = 2'd2,
      DONE   = 2'd3
   } state_t;

   // uio_in strobes
   localparam int UIO_VALID = 0;
   localparam int UIO_ABORT = 1;
   localparam int UIO_RD    = 2;

   // uio_out flags
   localparam int UIO_BUSY  = 3;
   localparam int UIO_DONE  = 4;
   localparam int UIO_COUT  = 5;
   localparam int UIO_LRDY  = 6;
   localparam int UIO_PHASE = 7;

   localparam logic [7:0] UIO_OE = 8'b1111_1000;

   function automatic int idx_width(input int nbytes);
      return (nbytes > 1) ? $clog2(nbytes) : 1;
   endfunction

endpackage

// File: rtl/adder8_cin.sv
// rtl/adder8_cin.sv - combinational 8-bit adder slice with carry-in
//
// Ports:
//   a, b  8-bit operand bytes
//   cin   carry from the previous byte
//   sum   low 8 bits of a + b + cin
//   cout  carry into the next byte
module adder8_cin (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - byte-serial NBYTES-wide adder built around one shared 8-bit slice
//
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   ena         power-good indication, unused
//   ui_in       operand byte, LSB first (A bytes, then B bytes)
//   uio_in      [0] valid, [1] abort, [2] rd; [7:3] unused
//   uo_out      result byte R[idx] while DONE, otherwise 0
//   uio_out     [3] busy, [4] done, [5] carry_out, [6] load_rdy, [7] phase; [2:0] = 0
//   uio_oe      constant UIO_OE
import adder_seq_pkg::*;

module adder_seq_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int             IW       = idx_width(NBYTES);
   localparam logic [IW-1:0]  IDX_LAST = IW'(NBYTES - 1);

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_nxt;
   logic          carry;
   logic          carry_nxt;
   logic          we_a;
   logic          we_b;
   logic          we_r;

   logic [7:0]    a_mem [NBYTES];
   logic [7:0]    b_mem [NBYTES];
   logic [7:0]    r_mem [NBYTES];

   logic [7:0]    slice_sum;
   logic          slice_cout;

   logic          valid;
   logic          abort;
   logic          rd;
   logic          idx_last;

   logic          unused_inputs;

   assign valid    = uio_in[UIO_VALID];
   assign abort    = uio_in[UIO_ABORT];
   assign rd       = uio_in[UIO_RD];
   assign idx_last = (idx == IDX_LAST);

   assign unused_inputs = &{1'b0, ena, uio_in[7:3]};

   // The one adder slice; the FSM walks idx across the operand bytes.
   adder8_cin u_slice (
      .a    (a_mem[idx]),
      .b    (b_mem[idx]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= LOAD_A;
         idx   <= '0;
         carry <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         carry <= carry_nxt;
      end
   end

   // Abort overrides every strobe; the byte stores are left as they are
   // because a fresh load rewrites every byte before they are used again.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      carry_nxt = carry;
      we_a      = 1'b0;
      we_b      = 1'b0;
      we_r      = 1'b0;

      if (abort) begin
         state_nxt = LOAD_A;
         idx_nxt   = '0;
         carry_nxt = 1'b0;
      end else begin
         case (state)
            LOAD_A: begin
               if (valid) begin
                  we_a = 1'b1;
                  if (idx_last) begin
                     idx_nxt   = '0;
                     state_nxt = LOAD_B;
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end
            end

            LOAD_B: begin
               if (valid) begin
                  we_b = 1'b1;
                  if (idx_last) begin
                     idx_nxt   = '0;
                     carry_nxt = 1'b0;
                     state_nxt = ADD;
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end
            end

            ADD: begin
               we_r      = 1'b1;
               carry_nxt = slice_cout;
               if (idx_last) begin
                  idx_nxt   = '0;
                  state_nxt = DONE;
               end else begin
                  idx_nxt = idx + 1'b1;
               end
            end

            DONE: begin
               if (rd) begin
                  if (idx_last) begin
                     idx_nxt   = '0;
                     state_nxt = LOAD_A;
                  end else begin
                     idx_nxt = idx + 1'b1;
                  end
               end
            end

            default: begin
               state_nxt = LOAD_A;
               idx_nxt   = '0;
               carry_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NBYTES; i++) begin
            a_mem[i] <= 8'h00;
            b_mem[i] <= 8'h00;
            r_mem[i] <= 8'h00;
         end
      end else begin
         if (we_a) a_mem[idx] <= ui_in;
         if (we_b) b_mem[idx] <= ui_in;
         if (we_r) r_mem[idx] <= slice_sum;
      end
   end

   assign uo_out = (state == DONE) ? r_mem[idx] : 8'h00;

   // In DONE the carry register holds the carry out of the top byte.
   always_comb begin
      uio_out            = 8'h00;
      uio_out[UIO_BUSY]  = (state == ADD);
      uio_out[UIO_DONE]  = (state == DONE);
      uio_out[UIO_COUT]  = carry & (state == DONE);
      uio_out[UIO_LRDY]  = (state == LOAD_A) || (state == LOAD_B);
      uio_out[UIO_PHASE] = (state == LOAD_B);
   end

   assign uio_oe = UIO_OE;

endmodule
